zorro_cycle_frontend: RTL
=========================

// Module: zorro_cycle_frontend
// PURPOSE
// Bus-side front end of the Zorro II board. Synchronises the asynchronous 68k
// strobes into z_sample_clk, tracks each bus cycle and decodes it as autoconfig
// or board-memory space. Hands each selected cycle to the card core (autoconfig
// regs / SDRAM arbiter) over a valid/ready request port, and returns read data
// to the bus.
// PARAMETERS
// SYNC_STAGES    2         flops per strobe synchroniser (>=2)
// CFG_BASE       24'hE80000 autoconfig window base, 64 KB (A23..A16 compare)
// MEM_SIZE_LOG2  21        board memory window size = 2^21 bytes (2 MB)
// PORTS
// z_sample_clk  in   1   sample clock (100 MHz); only clock
// reset_n       in   1   asynchronous active-low reset
// znAS,znUDS,znLDS in 1 each  async 68k strobes, active low
// zREAD         in   1   async, 1 = read cycle
// zDOE          in   1   async bus data output enable
// znCFGIN       in   1   async, 0 = this board may answer autoconfig
// zA            in   24  bus address (bit 0 ignored)
// zD_in         in   16  bus data in (writes)
// configured    in   1   autoconfig done; disables CFG window, enables MEM window
// mem_base      in   24-MEM_SIZE_LOG2  assigned base, A23..A21
// req_valid     out  1   request pending
// req_ready     in   1   core accepts request this cycle
// req_write     out  1   1 = write
// req_cfg       out  1   1 = autoconfig space, 0 = memory space
// req_addr      out  24  latched address, bit 0 forced 0
// req_be        out  2   {upper, lower} byte enables
// req_wdata     out  16  latched write data
// rsp_valid     in   1   read data valid (one-cycle pulse)
// rsp_rdata     in   16  read data
// zD_out        out  16  data to bus
// zD_oe         out  1   drive zD_out onto bus
// cycle_active  out  1   FSM not IDLE
// BEHAVIOUR
// - Reset: all outputs 0, FSM IDLE, synchronisers loaded with inactive levels
//   (strobes 1, zREAD 1, zDOE 0, znCFGIN 1).
// - Strobes/zREAD/zDOE/znCFGIN pass SYNC_STAGES flops; "as","ds" below are synced
//   values. zA and zD_in are sampled directly (stable before strobe edges).
// - IDLE: as low -> latch zA into req_addr; decode:
//   CFG hit = !configured & !znCFGIN_s & zA[23:16]==CFG_BASE[23:16];
//   MEM hit = configured & zA[23:MEM_SIZE_LOG2]==mem_base. Hit -> WAIT_DS, else
//   MISS. CFG check wins if both (cannot occur when configured).
// - MISS: wait as high -> IDLE. No request, no zD_oe.
// - WAIT_DS: (uds|lds) synced low -> SETTLE. as high first -> IDLE, no request.
// - SETTLE (1 cycle): latch req_be={~uds,~lds}, req_write=~zREAD_s,
//   req_wdata=zD_in; assert req_valid next cycle -> REQ.
// - REQ: req_valid and payload held stable until req_ready. Accept cycle: write
//   -> END; read -> RESP. AS release in REQ does not withdraw the request.
// - RESP: rsp_valid -> latch zD_out=rsp_rdata -> DRIVE. rsp_valid outside RESP ignored.
// - DRIVE: zD_oe = zREAD_s & zDOE_s & ~as (registered). as high -> zD_oe 0
//   same cycle as transition -> IDLE.
// - END: wait as high -> IDLE. If as already high at accept, IDLE next cycle.
// - Read latency: req_valid rises SYNC_STAGES+2 cycles after DS edge; zD_oe no
//   earlier than 1 cycle after rsp_valid.
// - Back-to-back cycles: new cycle only recognised after as seen high >=1 cycle.
// - reset_n low mid-cycle: immediate return to reset state, request dropped.
// - cycle_active=1 in every state except IDLE.
// TESTING
// 1 Autoconfig read: configured=0, znCFGIN=0, zA=E80000 -> req_cfg=1,
//   req_write=0, addr E80000, be=11; rsp 16'h1234 -> zD_out=1234, zD_oe while zDOE=1.
// 2 Memory write: configured=1, mem_base=3, zA=600000, zD=BEEF, both DS ->
//   req_write=1, req_cfg=0, addr 600000, wdata BEEF, be=11; nothing on zD_oe.
// 3 Miss: configured=1, zA=400000 -> no req_valid, no zD_oe; returns IDLE on AS high.
// 4 Backpressure: req_ready low 20 cycles, AS released meanwhile -> req_valid
//   and payload stable 20 cycles, one accept, then IDLE.
// 5 Byte lanes: only znLDS low at 600002 -> be=01; only znUDS -> be=10.
// 6 Abort/reset: AS released before DS -> no request; reset_n low in RESP ->
//   all outputs 0 next edge, next cycle decodes normally.

Source files
------------

// File: rtl/zorro_cycle_frontend.sv
// rtl/zorro_cycle_frontend.sv - Zorro II bus-cycle front end: strobe sync, decode, request/response hand-off
//
// Purpose:
//   Synchronises the asynchronous 68k bus strobes into z_sample_clk and follows
//   each bus cycle. A cycle is decoded as an autoconfig or a board-memory access.
//   A selected cycle goes to the card core as one valid/ready request. For a read,
//   the core's response data is driven back onto the bus.
//
// Ports:
//   z_sample_clk        sample clock, the only clock
//   reset_n             asynchronous active-low reset
//   znAS/znUDS/znLDS    async address/data strobes, active low
//   zREAD, zDOE         async read flag and bus data output enable
//   znCFGIN             async, low = this board may answer autoconfig
//   zA, zD_in           bus address (bit 0 ignored) and write data, sampled directly
//   configured          autoconfig done: CFG window off, MEM window on
//   mem_base            assigned memory base, A23..A(MEM_SIZE_LOG2)
//   req_*               request to the core, held until req_ready
//   rsp_valid/rsp_rdata single-cycle read response from the core
//   zD_out, zD_oe       read data and drive enable toward the bus
//   cycle_active        high whenever a bus cycle is being tracked
module zorro_cycle_frontend #(
    parameter int          SYNC_STAGES   = 2,
    parameter logic [23:0] CFG_BASE      = 24'hE80000,
    parameter int          MEM_SIZE_LOG2 = 21
) (
    input  logic                      z_sample_clk,
    input  logic                      reset_n,
    input  logic                      znAS,
    input  logic                      znUDS,
    input  logic                      znLDS,
    input  logic                      zREAD,
    input  logic                      zDOE,
    input  logic                      znCFGIN,
    input  logic [23:0]               zA,
    input  logic [15:0]               zD_in,
    input  logic                      configured,
    input  logic [23-MEM_SIZE_LOG2:0] mem_base,
    output logic                      req_valid,
    input  logic                      req_ready,
    output logic                      req_write,
    output logic                      req_cfg,
    output logic [23:0]               req_addr,
    output logic [1:0]                req_be,
    output logic [15:0]               req_wdata,
    input  logic                      rsp_valid,
    input  logic [15:0]               rsp_rdata,
    output logic [15:0]               zD_out,
    output logic                      zD_oe,
    output logic                      cycle_active
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MISS,
        ST_WAIT_DS,
        ST_SETTLE,
        ST_REQ,
        ST_RESP,
        ST_DRIVE,
        ST_END
    } state_t;

    // Synchroniser bit order: {znCFGIN, zDOE, zREAD, znLDS, znUDS, znAS}.
    // The reset value is the bus-idle level, so no false cycle starts at reset release.
    localparam logic [5:0] SYNC_RST = 6'b10_1111;

    logic [SYNC_STAGES-1:0][5:0] sync_q, sync_d;
    logic [5:0]                  sync_s;
    logic                        as_s, uds_s, lds_s, read_s, doe_s, cfgin_s;

    state_t        state_q, state_d;
    logic          as_seen_q, as_seen_d;
    logic          req_valid_q, req_valid_d;
    logic          req_write_q, req_write_d;
    logic          req_cfg_q, req_cfg_d;
    logic [23:0]   req_addr_q, req_addr_d;
    logic [1:0]    req_be_q, req_be_d;
    logic [15:0]   req_wdata_q, req_wdata_d;
    logic [15:0]   zd_out_q, zd_out_d;
    logic          zd_oe_q, zd_oe_d;

    logic          cfg_hit, mem_hit;
    logic          unused_za0;

    assign unused_za0 = zA[0];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], {znCFGIN, zDOE, zREAD, znLDS, znUDS, znAS}};
    end

    assign sync_s  = sync_q[SYNC_STAGES-1];
    assign as_s    = sync_s[0];
    assign uds_s   = sync_s[1];
    assign lds_s   = sync_s[2];
    assign read_s  = sync_s[3];
    assign doe_s   = sync_s[4];
    assign cfgin_s = sync_s[5];

    // zA is stable well before AS reaches us through the synchroniser.
    // It is therefore safe to decode zA directly, in the cycle where the synced AS falls.
    assign cfg_hit = !configured && !cfgin_s && (zA[23:16] == CFG_BASE[23:16]);
    assign mem_hit = configured && (zA[23:MEM_SIZE_LOG2] == mem_base);

    always_comb begin
        state_d     = state_q;
        as_seen_d   = as_seen_q;
        req_valid_d = req_valid_q;
        req_write_d = req_write_q;
        req_cfg_d   = req_cfg_q;
        req_addr_d  = req_addr_q;
        req_be_d    = req_be_q;
        req_wdata_d = req_wdata_q;
        zd_out_d    = zd_out_q;
        zd_oe_d     = 1'b0;

        // Remembers that AS went high since the last cycle started.
        // Because of this, a cycle that overlaps a held request is not started twice.
        // It also lets END finish without waiting for an AS edge that has already passed.
        if (as_s) begin
            as_seen_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (!as_s && as_seen_q) begin
                    as_seen_d  = 1'b0;
                    req_addr_d = {zA[23:1], 1'b0};
                    if (cfg_hit) begin
                        req_cfg_d = 1'b1;
                        state_d   = ST_WAIT_DS;
                    end else if (mem_hit) begin
                        req_cfg_d = 1'b0;
                        state_d   = ST_WAIT_DS;
                    end else begin
                        state_d = ST_MISS;
                    end
                end
            end
            ST_MISS: begin
                if (as_s) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_DS: begin
                if (as_s) begin
                    state_d = ST_IDLE;
                end else if (!uds_s || !lds_s) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                // One extra cycle lets the second data strobe land.
                // It also lets zD_in settle before we latch.
                req_be_d    = {~uds_s, ~lds_s};
                req_write_d = ~read_s;
                req_wdata_d = zD_in;
                req_valid_d = 1'b1;
                state_d     = ST_REQ;
            end
            ST_REQ: begin
                if (req_ready) begin
                    req_valid_d = 1'b0;
                    state_d     = req_write_q ? ST_END : ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_valid) begin
                    zd_out_d = rsp_rdata;
                    state_d  = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (as_s) begin
                    state_d = ST_IDLE;
                end else begin
                    zd_oe_d = read_s & doe_s;
                end
            end
            ST_END: begin
                if (as_s || as_seen_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge z_sample_clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q      <= {SYNC_STAGES{SYNC_RST}};
            state_q     <= ST_IDLE;
            as_seen_q   <= 1'b1;
            req_valid_q <= 1'b0;
            req_write_q <= 1'b0;
            req_cfg_q   <= 1'b0;
            req_addr_q  <= 24'h0;
            req_be_q    <= 2'b00;
            req_wdata_q <= 16'h0;
            zd_out_q    <= 16'h0;
            zd_oe_q     <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            as_seen_q   <= as_seen_d;
            req_valid_q <= req_valid_d;
            req_write_q <= req_write_d;
            req_cfg_q   <= req_cfg_d;
            req_addr_q  <= req_addr_d;
            req_be_q    <= req_be_d;
            req_wdata_q <= req_wdata_d;
            zd_out_q    <= zd_out_d;
            zd_oe_q     <= zd_oe_d;
        end
    end

    assign req_valid    = req_valid_q;
    assign req_write    = req_write_q;
    assign req_cfg      = req_cfg_q;
    assign req_addr     = req_addr_q;
    assign req_be       = req_be_q;
    assign req_wdata    = req_wdata_q;
    assign zD_out       = zd_out_q;
    assign zD_oe        = zd_oe_q;
    assign cycle_active = (state_q != ST_IDLE);

endmodule
